// File: rtl/instr_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_responder_pkg;

   localparam logic [31:0] IMEM_BASE_ADDR_DEFAULT = 32'h8000_0000;
   localparam int unsigned IMEM_FIFO_DEPTH        = 2;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
      logic        err;
   } imem_rsp_t;

   localparam int unsigned IMEM_RSP_W = $bits(imem_rsp_t);

   function automatic logic [29:0] imem_word_offset(input logic [31:0] addr,
                                                    input logic [31:0] base);
      return 30'((addr - base) >> 2);
   endfunction

endpackage

// File: rtl/instr_mem_responder_fifo.sv
// imem_rsp_fifo: 2-entry synchronous response FIFO with occupancy count and
// a synchronous clear; simultaneous push and pop keep order and occupancy.
module imem_rsp_fifo
   import instr_mem_responder_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [IMEM_RSP_W-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [IMEM_RSP_W-1:0] head_o,
   output logic [1:0]            count_o
);

   logic [IMEM_RSP_W-1:0] entry_q [IMEM_FIFO_DEPTH];
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;
   logic                  do_push;
   logic                  do_pop;

   always_comb begin
      do_pop  = pop_i && (count_q != '0);
      do_push = push_i && ((count_q != 2'(IMEM_FIFO_DEPTH)) || do_pop);
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < IMEM_FIFO_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            entry_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign head_o  = entry_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: preloadable word memory, one-cycle read, 2-entry
// response FIFO with credit-based req_ready. Optional macro IMEM_RANGE_CHECK_EN.
module instr_mem_responder
   import instr_mem_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = IMEM_BASE_ADDR_DEFAULT,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        flush_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic [31:0] rsp_addr_o,
   output logic        rsp_err_o,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   logic [31:0]           mem_q [DEPTH];
   logic [31:0]           rd_data_q;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic                  wr_in_range;
   logic                  req_misaligned;
   logic                  req_err;
   logic                  accept;
   logic                  rd_en;

   logic                  inflight_q,      inflight_d;
   logic [31:0]           inflight_addr_q, inflight_addr_d;
   logic                  inflight_err_q,  inflight_err_d;

   imem_rsp_t             push_rsp;
   imem_rsp_t             head_rsp;
   logic [IMEM_RSP_W-1:0] head_flat;
   logic [1:0]            fifo_count;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [2:0]            credit_used;

   assign req_idx        = DEPTH_LOG2'(imem_word_offset(req_addr_i, BASE_ADDR));
   assign wr_idx         = DEPTH_LOG2'(imem_word_offset(wr_addr_i, BASE_ADDR));
   assign wr_in_range    = (imem_word_offset(wr_addr_i, BASE_ADDR) >> DEPTH_LOG2) == '0;
   assign req_misaligned = req_addr_i[1:0] != 2'b00;

`ifdef IMEM_RANGE_CHECK_EN
   logic req_in_range;
   assign req_in_range = (imem_word_offset(req_addr_i, BASE_ADDR) >> DEPTH_LOG2) == '0;
   assign req_err      = req_misaligned || !req_in_range;
`else
   assign req_err      = req_misaligned;
`endif

   // A response popped this cycle frees its slot at the same edge, which is
   // what lets a steady stream run at one response per cycle.
   assign fifo_pop    = rsp_valid_o && rsp_ready_i;
   assign credit_used = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight_q};
   assign req_ready_o = rst_ni && !flush_i && (credit_used < 3'd2);
   assign accept      = req_valid_i && req_ready_o;
   assign rd_en       = accept && !req_err;

   // Nonblocking read of mem_q returns the pre-write word on a same-index write.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && wr_in_range) begin
         mem_q[wr_idx] <= wr_data_i;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[req_idx];
      end
   end

   always_comb begin
      inflight_d      = accept;
      inflight_addr_d = accept ? req_addr_i : inflight_addr_q;
      inflight_err_d  = accept ? req_err : inflight_err_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         inflight_err_q  <= 1'b0;
      end else begin
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         inflight_err_q  <= inflight_err_d;
      end
   end

   always_comb begin
      push_rsp.data = inflight_err_q ? '0 : rd_data_q;
      push_rsp.addr = inflight_addr_q;
      push_rsp.err  = inflight_err_q;
   end

   assign fifo_push = inflight_q && !flush_i;

   imem_rsp_fifo u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (flush_i),
      .push_i      (fifo_push),
      .push_data_i (push_rsp),
      .pop_i       (fifo_pop),
      .head_o      (head_flat),
      .count_o     (fifo_count)
   );

   assign head_rsp    = head_flat;
   assign rsp_valid_o = fifo_count != '0;
   assign rsp_data_o  = head_rsp.data;
   assign rsp_addr_o  = head_rsp.addr;
   assign rsp_err_o   = head_rsp.err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: expected responses are queued on
// request acceptance and compared in order when the response handshake fires.
module tb_instr_mem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] NEW_WORD = 32'h5A5A_1234;

   typedef struct {
      logic [31:0] data;
      logic [31:0] addr;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   int unsigned n_pop  = 0;

   logic [31:0] model_mem [256];
   exp_t        sb [$];

   instr_mem_responder #(
      .BASE_ADDR  (32'h8000_0000),
      .DEPTH_LOG2 (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .flush_i     (flush),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_addr_o  (rsp_addr),
      .rsp_err_o   (rsp_err),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] a);
      exp_t        r;
      logic [31:0] off;
      off    = (a - BASE) >> 2;
      r.addr = a;
      r.err  = (a[1:0] != 2'b00);
`ifdef IMEM_RANGE_CHECK_EN
      if (off >= 32'd256) r.err = 1'b1;
`endif
      r.data = r.err ? 32'h0 : model_mem[off[7:0]];
      return r;
   endfunction

   // Inputs change at posedge+1, so both handshakes are decided by negedge.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         sb.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            n_pop++;
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got response addr %h, required no response", rsp_addr);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({rsp_data, rsp_addr, rsp_err} !== {e.data, e.addr, e.err}) begin
                  n_fail++;
                  $display("FAIL sb_rsp: got data=%h addr=%h err=%b, required data=%h addr=%h err=%b",
                           rsp_data, rsp_addr, rsp_err, e.data, e.addr, e.err);
               end
            end
         end
         if (req_valid && req_ready) sb.push_back(model(req_addr));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] off;
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      off = (a - BASE) >> 2;
      if (off < 32'd256) model_mem[off[7:0]] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b1; req_addr = BASE; rsp_ready = 1'b1;
      flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", rsp_valid); end
      n_cmp++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", rsp_data); end
      n_cmp++; if (rsp_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h required 0", rsp_addr); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", rsp_err); end
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_req_ready: got %b required 1", req_ready); end
      @(posedge clk); #1;
   endtask

   task automatic preload();
      for (int i = 0; i < 16; i++) write_word(BASE + 32'(4 * i), 32'hA500_0000 ^ (32'(i) * 32'h0101_0101));
      // Out-of-range writes must leave word 0 intact.
      write_word(BASE + 32'h400, 32'hDEAD_BEEF);
      write_word(BASE - 32'h4, 32'hBAD0_BAD0);
   endtask

   task automatic test_back_to_back();
      int unsigned pop0;
      pop0 = n_pop; rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = BASE;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b required 1", req_ready); end
      @(posedge clk); #1; req_addr = BASE + 32'h4;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency_early: got %b required 0", rsp_valid); end
      @(posedge clk); #1; req_addr = BASE + 32'h8;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b required 1", rsp_valid); end
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %b required 1", rsp_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_third: got %b required 1", rsp_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b required 0", rsp_valid); end
      @(posedge clk); #1;
      n_cmp++; if (n_pop - pop0 != 3) begin n_fail++; $display("FAIL b2b_count: got %0d required 3", n_pop - pop0); end
   endtask

   task automatic test_backpressure();
      int unsigned acc;
      logic        took;
      acc = 0; rsp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE + 32'h10;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         took = req_ready;
         if (took) acc++;
         @(posedge clk); #1;
         if (took) req_addr = req_addr + 32'h4;
      end
      n_cmp++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d required 2", acc); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b required 0", req_ready); end
         n_cmp++; if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, BASE + 32'h10, model_mem[4]}) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b addr=%h data=%h required v=1 addr=%h data=%h",
                     rsp_valid, rsp_addr, rsp_data, BASE + 32'h10, model_mem[4]);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1; req_valid = 1'b0;
      for (int k = 0; k < 10 && sb.size() != 0; k++) begin @(posedge clk); #1; end
      n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending required 0", sb.size()); end
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b required 1", req_ready); end
   endtask

   task automatic test_misaligned();
      logic got;
      got = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = BASE + 32'h2;
      @(negedge clk);
      @(posedge clk); #1; req_valid = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = rsp_valid; end
      n_cmp++;
      if (!got) begin
         n_fail++; $display("FAIL mis_timeout: got no response required one");
      end else if ({rsp_err, rsp_data, rsp_addr} !== {1'b1, 32'h0, BASE + 32'h2}) begin
         n_fail++;
         $display("FAIL mis_rsp: got err=%b data=%h addr=%h required err=1 data=0 addr=%h",
                  rsp_err, rsp_data, rsp_addr, BASE + 32'h2);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_range();
      logic        got;
      logic        e_err;
      logic [31:0] e_data;
`ifdef IMEM_RANGE_CHECK_EN
      e_err = 1'b1; e_data = 32'h0;
`else
      e_err = 1'b0; e_data = model_mem[0];
`endif
      got = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = BASE + 32'h400;
      @(negedge clk);
      @(posedge clk); #1; req_valid = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = rsp_valid; end
      n_cmp++;
      if (!got) begin
         n_fail++; $display("FAIL range_timeout: got no response required one");
      end else if ({rsp_err, rsp_data} !== {e_err, e_data}) begin
         n_fail++;
         $display("FAIL range_rsp: got err=%b data=%h required err=%b data=%h", rsp_err, rsp_data, e_err, e_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      int unsigned acc;
      int unsigned pop0;
      logic        got;
      acc = 0; rsp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE + 32'h20;
      for (int k = 0; k < 6 && acc < 2; k++) begin
         @(negedge clk);
         if (req_ready) acc++;
         @(posedge clk); #1;
         req_addr = req_addr + 32'h4;
      end
      n_cmp++; if (acc != 2) begin n_fail++; $display("FAIL fl_setup: got %0d accepts required 2", acc); end
      flush = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready: got %b required 0", req_ready); end
      @(posedge clk); #1; flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b required 0", rsp_valid); end
      @(posedge clk); #1; rsp_ready = 1'b1; pop0 = n_pop;
      repeat (4) begin @(posedge clk); #1; end
      n_cmp++; if (n_pop != pop0) begin n_fail++; $display("FAIL fl_stale: got %0d responses required 0", n_pop - pop0); end
      got = 1'b0; req_valid = 1'b1; req_addr = BASE + 32'h30;
      @(negedge clk);
      @(posedge clk); #1; req_valid = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = rsp_valid; end
      n_cmp++;
      if (!got || rsp_data !== model_mem[12]) begin
         n_fail++; $display("FAIL fl_after: got v=%b data=%h required v=1 data=%h", got, rsp_data, model_mem[12]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_collision();
      logic [31:0] old_v;
      logic        got;
      old_v = model_mem[4]; rsp_ready = 1'b1;
      wr_en = 1'b1; wr_addr = BASE + 32'h10; wr_data = NEW_WORD;
      req_valid = 1'b1; req_addr = BASE + 32'h10;
      @(negedge clk);
      @(posedge clk); #1;
      wr_en = 1'b0; req_valid = 1'b0; model_mem[4] = NEW_WORD;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = rsp_valid; end
      n_cmp++;
      if (!got || rsp_data !== old_v) begin
         n_fail++; $display("FAIL col_old: got v=%b data=%h required v=1 data=%h", got, rsp_data, old_v);
      end
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = BASE + 32'h10;
      @(negedge clk);
      @(posedge clk); #1; req_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = rsp_valid; end
      n_cmp++;
      if (!got || rsp_data !== NEW_WORD) begin
         n_fail++; $display("FAIL col_new: got v=%b data=%h required v=1 data=%h", got, rsp_data, NEW_WORD);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int unsigned pop0;
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE + 32'h8;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0; req_valid = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b required 0", rsp_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1; rsp_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b required 1", req_ready); end
      pop0 = n_pop;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (n_pop != pop0) begin n_fail++; $display("FAIL rm_stale: got %0d responses required 0", n_pop - pop0); end
      req_valid = 1'b1; req_addr = BASE + 32'h0C;
      @(negedge clk);
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      n_cmp++; if (n_pop - pop0 != 1) begin n_fail++; $display("FAIL rm_after: got %0d responses required 1", n_pop - pop0); end
   endtask

   initial begin
      test_reset();
      preload();
      test_back_to_back();
      test_backpressure();
      test_misaligned();
      test_range();
      test_flush();
      test_collision();
      test_reset_mid();
      repeat (2) begin @(posedge clk); #1; end
      n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending required 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
